disparity_wta: RTL and testbench

Winner-take-all disparity selector: the stage directly downstream of the Hamming-cost popcount. For each pixel it receives NDISP matching costs serially, one per valid cycle, in disparity order 0..NDISP-1. It tracks the minimum cost, its index and the second-smallest cost, then emits the winning disparity, its cost and a uniqueness flag. The output feeds the disparity-map writer.

---
 rtl/disparity_wta.sv | 124 ++++++++++++
 tb/tb_disparity_wta.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector.
// Consumes NDISP matching costs per pixel, one per valid beat, in disparity
// order 0..NDISP-1. Tracks the minimum cost, its index and the runner-up cost,
// and after the last beat emits the winning disparity, its cost and a
// uniqueness flag.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rstn    synchronous active-low reset
//   i_dval    i_data valid this cycle
//   i_first   with i_dval: disparity-0 cost of a new pixel
//   i_data    matching cost for the current disparity index
//   o_dval    one-cycle pulse, result registers updated
//   o_data    winning disparity index
//   o_cost    winning (minimum) cost
//   o_unique  1 when (second - best) >= MARGIN
module disparity_wta #(
   parameter int unsigned NDISP  = 64,
   parameter int unsigned CW     = 5,
   parameter int unsigned MARGIN = 2,
   localparam int unsigned DW    = $clog2(NDISP)
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_dval,
   input  logic          i_first,
   input  logic [CW-1:0] i_data,
   output logic          o_dval,
   output logic [DW-1:0] o_data,
   output logic [CW-1:0] o_cost,
   output logic          o_unique
);

   localparam logic [DW-1:0] LastIdx = DW'(NDISP - 1);

   typedef enum logic {StIdle, StAccum} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] best_q, best_d;
   logic [DW-1:0] best_idx_q, best_idx_d;
   logic [CW-1:0] second_q, second_d;
   logic          dval_q, dval_d;
   logic [DW-1:0] data_q, data_d;
   logic [CW-1:0] cost_q, cost_d;
   logic          unique_q, unique_d;
   logic [CW:0]   gap;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      second_d   = second_q;
      dval_d     = 1'b0;
      data_d     = data_q;
      cost_d     = cost_q;
      unique_d   = unique_q;
      gap        = '0;

      if (i_dval) begin
         if (i_first) begin
            // A first beat always starts a fresh pixel, aborting any in flight.
            best_d     = i_data;
            best_idx_d = '0;
            second_d   = '1;
            cnt_d      = DW'(1);
            state_d    = StAccum;
         end else if (state_q == StAccum) begin
            // Strict compares: on ties the earlier (lower) index keeps the win.
            if (i_data < best_q) begin
               second_d   = best_q;
               best_d     = i_data;
               best_idx_d = cnt_q;
            end else if (i_data < second_q) begin
               second_d = i_data;
            end

            if (cnt_q == LastIdx) begin
               // Result includes this beat, so use the updated min/second.
               gap      = {1'b0, second_d} - {1'b0, best_d};
               dval_d   = 1'b1;
               data_d   = best_idx_d;
               cost_d   = best_d;
               unique_d = (gap >= (CW + 1)'(MARGIN));
               cnt_d    = '0;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         second_q   <= '1;
         dval_q     <= 1'b0;
         data_q     <= '0;
         cost_q     <= '0;
         unique_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         second_q   <= second_d;
         dval_q     <= dval_d;
         data_q     <= data_d;
         cost_q     <= cost_d;
         unique_q   <= unique_d;
      end
   end

   assign o_dval   = dval_q;
   assign o_data   = data_q;
   assign o_cost   = cost_q;
   assign o_unique = unique_q;

endmodule

// File: tb/tb_disparity_wta.sv
// Self-checking bench for disparity_wta (NDISP = 4, CW = 5, MARGIN = 2).
// A behavioural model collects each pixel's costs in a queue and, once the
// pixel is complete, scans it for the minimum and runner-up. Every cycle the
// DUT outputs are compared with the model's expected outputs.
module tb_disparity_wta;

   localparam int unsigned NDISP  = 4;
   localparam int unsigned CW     = 5;
   localparam int unsigned MARGIN = 2;
   localparam int unsigned DW     = $clog2(NDISP);

   typedef int pix_t [NDISP];

   logic          clk;
   logic          rstn;
   logic          dval;
   logic          first;
   logic [CW-1:0] data;
   logic          o_dval;
   logic [DW-1:0] o_data;
   logic [CW-1:0] o_cost;
   logic          o_unique;

   int errors = 0;
   int checks = 0;

   // Model state.
   int q[$];
   bit active = 0;
   int m_dval = 0, m_data = 0, m_cost = 0, m_unique = 0;

   disparity_wta #(
      .NDISP  (NDISP),
      .CW     (CW),
      .MARGIN (MARGIN)
   ) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_dval   (dval),
      .i_first  (first),
      .i_data   (data),
      .o_dval   (o_dval),
      .o_data   (o_data),
      .o_cost   (o_cost),
      .o_unique (o_unique)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference result of a complete pixel.
   task automatic model_result();
      int b, bi, s;
      b  = q[0];
      bi = 0;
      for (int i = 1; i < NDISP; i++)
         if (q[i] < b) begin
            b  = q[i];
            bi = i;
         end
      s = (1 << CW) - 1;
      for (int i = 0; i < NDISP; i++)
         if (i != bi && q[i] < s) s = q[i];
      m_dval   = 1;
      m_data   = bi;
      m_cost   = b;
      m_unique = ((s - b) >= int'(MARGIN)) ? 1 : 0;
   endtask

   // One clock cycle: drive, clock, update model, compare.
   task automatic step(input bit r, input bit v, input bit f, input int d);
      rstn  = r;
      dval  = v;
      first = f;
      data  = CW'(d);
      @(posedge clk);
      #1;
      m_dval = 0;
      if (!r) begin
         q.delete();
         active   = 0;
         m_data   = 0;
         m_cost   = 0;
         m_unique = 0;
      end else if (v && f) begin
         q.delete();
         q.push_back(d);
         active = 1;
      end else if (v && active) begin
         q.push_back(d);
         if (q.size() == NDISP) begin
            model_result();
            active = 0;
         end
      end
      check_eq("o_dval", int'(o_dval), m_dval);
      check_eq("o_data", int'(o_data), m_data);
      check_eq("o_cost", int'(o_cost), m_cost);
      check_eq("o_unique", int'(o_unique), m_unique);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, $urandom_range(0, 31));
   endtask

   task automatic send_pix(input pix_t c, input int gap);
      for (int i = 0; i < NDISP; i++) begin
         if (i > 0) idle(gap);
         step(1, 1, (i == 0), c[i]);
      end
   endtask

   initial begin
      pix_t p;
      int   act, gmax;
      rstn  = 1'b0;
      dval  = 1'b0;
      first = 1'b0;
      data  = '0;

      // Reset held for 3 cycles while beats are driven.
      step(0, 1, 1, 9);
      step(0, 1, 0, 1);
      step(0, 1, 0, 2);
      idle(1);

      // Directed cases.
      send_pix('{9, 3, 7, 12}, 0);
      idle(1);
      send_pix('{5, 2, 2, 3}, 0);
      send_pix('{4, 6, 5, 5}, 0);
      idle(2);
      send_pix('{8, 1, 8, 8}, 2);
      send_pix('{0, 9, 9, 9}, 0);
      idle(2);
      step(1, 1, 1, 6);
      step(1, 1, 0, 6);
      send_pix('{3, 1, 4, 4}, 0);
      idle(1);
      send_pix('{20, 20, 20, 0}, 1);
      // Stray non-first beats while idle.
      step(1, 1, 0, 5);
      step(1, 1, 0, 0);
      idle(1);
      send_pix('{31, 31, 31, 31}, 0);
      // Last beat coinciding with reset: no result.
      step(1, 1, 1, 7);
      step(1, 1, 0, 3);
      step(1, 1, 0, 2);
      step(0, 1, 0, 1);
      idle(1);

      // Randomized traffic.
      for (int it = 0; it < 300; it++) begin
         act  = $urandom_range(0, 99);
         gmax = ($urandom_range(0, 3) == 0) ? 2 : 0;
         for (int i = 0; i < NDISP; i++)
            p[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
         if (act < 65) begin
            send_pix(p, $urandom_range(0, gmax));
         end else if (act < 78) begin
            // Partial pixel that the next pixel aborts.
            for (int i = 0; i < $urandom_range(1, NDISP - 1); i++)
               step(1, 1, (i == 0), p[i]);
            send_pix(p, 0);
         end else if (act < 88) begin
            step(1, 1, 0, p[0]);
         end else if (act < 94) begin
            idle($urandom_range(1, 3));
         end else begin
            step(1, 1, 1, p[0]);
            step(0, $urandom_range(0, 1), 0, p[1]);
         end
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
